// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: EX forwarding, load-use stall, flush gating,
// halt-drain FSM, debug single-step and active-cycle counter.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int NB_CNT       = 32
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic [4:0]        i_ifid_rs,
  input  logic [4:0]        i_ifid_rt,
  input  logic [4:0]        i_idex_rs,
  input  logic [4:0]        i_idex_rt,
  input  logic              i_idex_memRead,
  input  logic [4:0]        i_idex_write_reg,
  input  logic              i_exmem_regWrite,
  input  logic [4:0]        i_exmem_write_reg,
  input  logic              i_memwb_regWrite,
  input  logic [4:0]        i_memwb_write_reg,
  input  logic              i_halt_instr,
  input  logic              i_branch_taken,
  input  logic              i_run_mode,
  input  logic              i_step,
  output logic [1:0]        o_fw_a,
  output logic [1:0]        o_fw_b,
  output logic              o_stall,
  output logic              o_flush,
  output logic              o_halt,
  output logic              o_halted,
  output logic [2:0]        o_state,
  output logic [NB_CNT-1:0] o_cycle_cnt
);

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam int NB_DR =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DR-1:0] DR_INIT =
    NB_DR'(DRAIN_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [NB_DR-1:0]  drain_q, drain_d;
  logic              step_q;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  logic ex_a, ex_b, wb_a, wb_b;
  logic load_use;
  logic step_rise;
  logic halt_go;
  logic stall_w, halt_w, halted_w;

  // Register 0 is hardwired, so a write to it never forwards.
  assign ex_a = i_exmem_regWrite
             && (i_exmem_write_reg != 5'd0)
             && (i_exmem_write_reg == i_idex_rs);
  assign ex_b = i_exmem_regWrite
             && (i_exmem_write_reg != 5'd0)
             && (i_exmem_write_reg == i_idex_rt);
  assign wb_a = i_memwb_regWrite
             && (i_memwb_write_reg != 5'd0)
             && (i_memwb_write_reg == i_idex_rs);
  assign wb_b = i_memwb_regWrite
             && (i_memwb_write_reg != 5'd0)
             && (i_memwb_write_reg == i_idex_rt);

  always_comb begin
    o_fw_a = 2'b00;
    if (ex_a)      o_fw_a = 2'b11;
    else if (wb_a) o_fw_a = 2'b10;
  end

  always_comb begin
    o_fw_b = 2'b00;
    if (ex_b)      o_fw_b = 2'b11;
    else if (wb_b) o_fw_b = 2'b10;
  end

  assign load_use = i_idex_memRead
                 && (i_idex_write_reg != 5'd0)
                 && ((i_idex_write_reg == i_ifid_rs)
                  || (i_idex_write_reg == i_ifid_rt));

  assign step_rise = i_step && !step_q;
  // A HALT stuck behind a load-use bubble waits until the bubble clears.
  assign halt_go = i_halt_instr && !load_use;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt_go) begin
          state_d = ST_DRAIN;
          drain_d = DR_INIT;
        end else if (!i_run_mode) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (step_rise)       state_d = ST_STEP;
        else if (i_run_mode) state_d = ST_RUN;
      end
      ST_STEP: begin
        if (halt_go) begin
          state_d = ST_DRAIN;
          drain_d = DR_INIT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_HALTED;
        else               drain_d = drain_q - 1'b1;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    halt_w   = 1'b1;
    stall_w  = 1'b0;
    halted_w = 1'b0;
    unique case (state_q)
      ST_RUN, ST_STEP: begin
        halt_w  = 1'b0;
        stall_w = load_use;
      end
      ST_DRAIN: begin
        halt_w  = 1'b0;
        stall_w = 1'b1;
      end
      ST_HALTED: halted_w = 1'b1;
      default:   halt_w   = 1'b1;
    endcase
  end

  assign o_stall  = stall_w;
  assign o_halt   = halt_w;
  assign o_halted = halted_w;
  assign o_flush  = i_branch_taken && !stall_w && !halt_w;
  assign o_state  = state_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!halt_w && (cnt_q != '1)) cnt_d = cnt_q + NB_CNT'(1);
  end

  assign o_cycle_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= i_run_mode ? ST_RUN : ST_WAIT;
      drain_q <= '0;
      step_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      step_q  <= i_step;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a queue of expected outputs
// popped and compared on the falling edge.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [4:0]  i_ifid_rs, i_ifid_rt, i_idex_rs, i_idex_rt;
  logic        i_idex_memRead;
  logic [4:0]  i_idex_write_reg;
  logic        i_exmem_regWrite;
  logic [4:0]  i_exmem_write_reg;
  logic        i_memwb_regWrite;
  logic [4:0]  i_memwb_write_reg;
  logic        i_halt_instr, i_branch_taken, i_run_mode, i_step;
  logic [1:0]  o_fw_a, o_fw_b;
  logic        o_stall, o_flush, o_halt, o_halted;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .NB_CNT(32)) dut (
    .clk(clk),
    .i_rst(i_rst),
    .i_ifid_rs(i_ifid_rs),
    .i_ifid_rt(i_ifid_rt),
    .i_idex_rs(i_idex_rs),
    .i_idex_rt(i_idex_rt),
    .i_idex_memRead(i_idex_memRead),
    .i_idex_write_reg(i_idex_write_reg),
    .i_exmem_regWrite(i_exmem_regWrite),
    .i_exmem_write_reg(i_exmem_write_reg),
    .i_memwb_regWrite(i_memwb_regWrite),
    .i_memwb_write_reg(i_memwb_write_reg),
    .i_halt_instr(i_halt_instr),
    .i_branch_taken(i_branch_taken),
    .i_run_mode(i_run_mode),
    .i_step(i_step),
    .o_fw_a(o_fw_a),
    .o_fw_b(o_fw_b),
    .o_stall(o_stall),
    .o_flush(o_flush),
    .o_halt(o_halt),
    .o_halted(o_halted),
    .o_state(o_state),
    .o_cycle_cnt(o_cycle_cnt)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic        m_halt = 1'b1;
  logic [31:0] m_cnt  = 32'd0;

  task automatic push(input string tag, input int sel,
                      input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_ctl(input string tag, input logic [2:0] st,
                         input logic h, input logic s,
                         input logic f, input logic hd);
    push({tag, ".state"},  0, 32'(st));
    push({tag, ".halt"},   1, 32'(h));
    push({tag, ".stall"},  2, 32'(s));
    push({tag, ".flush"},  3, 32'(f));
    push({tag, ".halted"}, 4, 32'(hd));
    push({tag, ".cnt"},    5, m_cnt);
    m_halt = h;
  endtask

  task automatic exp_fw(input string tag, input logic [1:0] a,
                        input logic [1:0] b);
    push({tag, ".fw_a"}, 6, 32'(a));
    push({tag, ".fw_b"}, 7, 32'(b));
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return 32'(o_state);
      1:       return 32'(o_halt);
      2:       return 32'(o_stall);
      3:       return 32'(o_flush);
      4:       return 32'(o_halted);
      5:       return o_cycle_cnt;
      6:       return 32'(o_fw_a);
      default: return 32'(o_fw_b);
    endcase
  endfunction

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h",
               e.tag, obs, e.val);
      end
    end
  endtask

  // Expected counter: advances on edges that close a non-halted cycle.
  task automatic tick();
    @(posedge clk);
    if (i_rst) m_cnt = 32'd0;
    else if (!m_halt && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_run_mode = 1'b1; i_step = 1'b0;
    i_ifid_rs = '0; i_ifid_rt = '0; i_idex_rs = '0; i_idex_rt = '0;
    i_idex_memRead = 1'b0; i_idex_write_reg = '0;
    i_exmem_regWrite = 1'b0; i_exmem_write_reg = '0;
    i_memwb_regWrite = 1'b0; i_memwb_write_reg = '0;
    i_halt_instr = 1'b0; i_branch_taken = 1'b0;

    tick(); i_rst = 1'b0;
    exp_ctl("rst_run", 3'd0, 0, 0, 0, 0); check();

    tick();
    i_exmem_regWrite = 1; i_exmem_write_reg = 5;
    i_memwb_regWrite = 1; i_memwb_write_reg = 5;
    i_idex_rs = 5; i_idex_rt = 5;
    exp_fw("fw_ex", 2'b11, 2'b11);
    exp_ctl("a1", 3'd0, 0, 0, 0, 0); check();

    tick(); i_exmem_regWrite = 0;
    exp_fw("fw_wb", 2'b10, 2'b10);
    exp_ctl("a2", 3'd0, 0, 0, 0, 0); check();

    tick();
    i_exmem_regWrite = 1; i_exmem_write_reg = 0;
    i_memwb_write_reg = 0; i_idex_rs = 0; i_idex_rt = 0;
    exp_fw("fw_r0", 2'b00, 2'b00);
    exp_ctl("a3", 3'd0, 0, 0, 0, 0); check();

    tick();
    i_exmem_write_reg = 5; i_memwb_write_reg = 6;
    i_idex_rs = 5; i_idex_rt = 6;
    exp_fw("fw_mix", 2'b11, 2'b10);
    exp_ctl("a4", 3'd0, 0, 0, 0, 0); check();

    tick();
    i_exmem_write_reg = 0; i_memwb_write_reg = 5;
    i_idex_rs = 5; i_idex_rt = 5;
    exp_fw("fw_ex0", 2'b10, 2'b10);
    exp_ctl("a5", 3'd0, 0, 0, 0, 0); check();

    tick();
    i_exmem_regWrite = 0; i_memwb_regWrite = 0;
    i_idex_memRead = 1; i_idex_write_reg = 8; i_ifid_rt = 8;
    i_branch_taken = 1;
    exp_ctl("lu_stall", 3'd0, 0, 1, 0, 0); check();

    tick(); i_idex_memRead = 0;
    exp_ctl("lu_clear", 3'd0, 0, 0, 1, 0); check();

    tick(); i_branch_taken = 0; i_halt_instr = 1;
    exp_ctl("halt_pulse", 3'd0, 0, 0, 0, 0); check();

    tick(); i_halt_instr = 0; i_branch_taken = 1;
    exp_ctl("drain1", 3'd3, 0, 1, 0, 0); check();

    tick(); i_run_mode = 0; i_step = 1;
    exp_ctl("drain2", 3'd3, 0, 1, 0, 0); check();

    tick(); i_step = 0;
    exp_ctl("drain3", 3'd3, 0, 1, 0, 0); check();

    tick();
    exp_ctl("halted1", 3'd4, 1, 0, 0, 1); check();

    tick(); i_step = 1;
    exp_ctl("halted2", 3'd4, 1, 0, 0, 1); check();

    tick(); i_step = 0; i_branch_taken = 0; i_rst = 1;
    exp_ctl("halted3", 3'd4, 1, 0, 0, 1); check();

    tick(); i_rst = 0;
    exp_ctl("rst_wait", 3'd1, 1, 0, 0, 0); check();

    tick(); i_step = 1;
    exp_ctl("w_rise", 3'd1, 1, 0, 0, 0); check();
    tick();
    exp_ctl("step1", 3'd2, 0, 0, 0, 0); check();
    tick();
    exp_ctl("w_hold1", 3'd1, 1, 0, 0, 0); check();
    tick();
    exp_ctl("w_hold2", 3'd1, 1, 0, 0, 0); check();
    tick();
    exp_ctl("w_hold3", 3'd1, 1, 0, 0, 0); check();
    tick(); i_step = 0;
    exp_ctl("w_low", 3'd1, 1, 0, 0, 0); check();
    tick(); i_step = 1;
    exp_ctl("w_rise2", 3'd1, 1, 0, 0, 0); check();
    tick();
    exp_ctl("step2", 3'd2, 0, 0, 0, 0); check();
    tick(); i_step = 0;
    exp_ctl("w_after2", 3'd1, 1, 0, 0, 0); check();
    tick(); i_run_mode = 1;
    exp_ctl("w_to_run", 3'd1, 1, 0, 0, 0); check();

    tick();
    i_halt_instr = 1; i_idex_memRead = 1;
    i_idex_write_reg = 3; i_ifid_rs = 3; i_branch_taken = 1;
    exp_ctl("halt_lu", 3'd0, 0, 1, 0, 0); check();
    tick(); i_idex_memRead = 0; i_branch_taken = 0;
    exp_ctl("halt_retry", 3'd0, 0, 0, 0, 0); check();
    tick(); i_halt_instr = 0;
    exp_ctl("drain_b1", 3'd3, 0, 1, 0, 0); check();
    tick(); i_rst = 1;
    exp_ctl("drain_b2", 3'd3, 0, 1, 0, 0); check();
    tick(); i_rst = 0;
    exp_ctl("rst_drain", 3'd0, 0, 0, 0, 0); check();
    tick();
    exp_ctl("run_after", 3'd0, 0, 0, 0, 0); check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencing controller for the 5-stage MIPS pipeline.
- Generates the EX-stage forwarding selects and load-use stalls, and gates branch flushes.
- Runs the halt-drain sequence and the debug single-step mode.
- Drives the pipeline-wide halt that freezes every stage register, plus a saturating active-cycle counter for the debug unit.

Parameters:
- DRAIN_CYCLES, 3, cycles between HALT detection in ID and final freeze (EX, MEM, WB drain).
- NB_CNT, 32, width of o_cycle_cnt.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_ifid_rs  in  5  rs of instruction in ID.
- i_ifid_rt  in  5  rt of instruction in ID.
- i_idex_rs  in  5  rs of instruction in EX.
- i_idex_rt  in  5  rt of instruction in EX.
- i_idex_memRead  in  1  instruction in EX is a load.
- i_idex_write_reg  in  5  destination of instruction in EX.
- i_exmem_regWrite  in  1  EX/MEM writes a register.
- i_exmem_write_reg  in  5  EX/MEM destination.
- i_memwb_regWrite  in  1  MEM/WB writes a register.
- i_memwb_write_reg  in  5  MEM/WB destination.
- i_halt_instr  in  1  HALT decoded in ID.
- i_branch_taken  in  1  branch/jump resolved taken in ID.
- i_run_mode  in  1  1 = continuous, 0 = single-step.
- i_step  in  1  debug step request (level; rising edge used).
- o_fw_a  out  2  EX operand A select: 00 reg, 11 EX/MEM, 10 MEM/WB.
- o_fw_b  out  2  EX operand B select, same encoding.
- o_stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX.
- o_flush  out  1  clear IF/ID.
- o_halt  out  1  freeze all pipeline registers.
- o_halted  out  1  program finished.
- o_state  out  3  current FSM state encoding.
- o_cycle_cnt  out  NB_CNT  count of cycles with o_halt=0.

Behaviour:
Forwarding (combinational, all states):
- o_fw_a = 11 if i_exmem_regWrite, i_exmem_write_reg != 0 and i_exmem_write_reg == i_idex_rs.
- Else o_fw_a = 10 if the same conditions hold on the MEM/WB inputs.
- Else o_fw_a = 00.
- o_fw_b is identical, using i_idex_rt.
- EX/MEM has priority over MEM/WB.
- Register 0 never forwards.

Load-use hazard:
- load_use = i_idex_memRead && i_idex_write_reg != 0 && (i_idex_write_reg == i_ifid_rs || i_idex_write_reg == i_ifid_rt).
- In RUN or STEP: o_stall = load_use. The hazard clears itself after one bubble.
- o_flush = i_branch_taken && !o_stall && o_halt == 0; stall wins over flush.

FSM states (o_state): RUN=0, WAIT=1, STEP=2, DRAIN=3, HALTED=4.
- Reset: state = WAIT if i_run_mode=0, else RUN; counter and o_cycle_cnt = 0; step edge register = 0.
- Reset values of outputs: o_stall=0, o_flush=0, o_halted=0. o_halt=1 in WAIT, 0 in RUN.
- Reset mid-operation (any state, including DRAIN) aborts immediately with the same values.
- RUN:
  - o_halt=0.
  - i_halt_instr && !load_use: go to DRAIN, drain counter = DRAIN_CYCLES-1.
  - Else if i_run_mode=0: go to WAIT.
  - Halt takes priority over the mode change.
- WAIT:
  - o_halt=1, o_stall=0, o_flush=0.
  - Rising edge of i_step (i_step=1, previous sample 0): go to STEP.
  - Else if i_run_mode=1: go to RUN.
- STEP:
  - o_halt=0 for exactly one cycle.
  - Next state is DRAIN if i_halt_instr && !load_use, else WAIT.
  - A load-use stall in STEP consumes that step.
- DRAIN:
  - o_halt=0, o_stall=1 (no new fetch), o_flush=0.
  - Counter decrements each cycle; when it equals 0, next state is HALTED.
  - DRAIN lasts exactly DRAIN_CYCLES cycles.
  - Ignores i_step, i_run_mode and i_branch_taken.
- HALTED:
  - o_halt=1, o_halted=1, o_stall=0.
  - Terminal until i_rst.

Cycle counter:
- o_cycle_cnt increments on every cycle with o_halt=0.
- Saturates at all-ones.

Latency:
- Forwarding, stall and flush are same-cycle.
- State changes take effect in the cycle after the triggering input.

Test Plan:
- i_exmem_regWrite=1, i_exmem_write_reg=5, i_memwb_regWrite=1, i_memwb_write_reg=5, i_idex_rs=5, i_idex_rt=5 -> o_fw_a=11, o_fw_b=11.
  - Set i_exmem_regWrite=0 -> o_fw_a=10, o_fw_b=10.
  - Any destination of 0 -> o_fw_a=00, o_fw_b=00.
- RUN, i_idex_memRead=1, i_idex_write_reg=8, i_ifid_rt=8, i_branch_taken=1 -> o_stall=1, o_flush=0 that cycle.
  - Next cycle, with i_idex_memRead=0 -> o_stall=0, o_flush=1.
- RUN, one-cycle i_halt_instr pulse, DRAIN_CYCLES=3 -> o_state=3 with o_stall=1 for exactly 3 cycles.
  - Then o_state=4, o_halt=1, o_halted=1.
  - o_cycle_cnt stops changing.
- Reset with i_run_mode=0 -> o_state=1, o_halt=1.
  - Hold i_step high 5 cycles -> exactly one cycle with o_halt=0, o_cycle_cnt=1.
  - Second rising edge -> o_cycle_cnt=2.
- i_halt_instr asserted together with load_use -> no DRAIN entry that cycle.
  - DRAIN is entered the next cycle, after load_use clears.
- i_rst asserted in DRAIN with the counter at 1 -> next cycle o_state=0 (i_run_mode=1), o_cycle_cnt=0, o_halted=0.
